if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- IF/ID pipeline register plus load-use hazard detector, directly downstream of the instruction fetch stage.
- Captures the fetched instruction and its PC and presents them to decode.
- Feeds fetch its control: opcjump/jumpPC from the held instruction, and the active-low-stall hazardFlag.
- Flushes on taken branch; inserts one ID/EX bubble per load-use hazard.

Parameters:
- PC_W, 10, PC / jump-target width
- INSTR_W, 32, instruction width

Ports:
- clk  in  1  clock; all state updates on posedge (fetch updates PC on negedge)
- reset  in  1  synchronous, active-high
- Instruction  in  INSTR_W  fetch output (ROM data for current PC)
- PC  in  PC_W  fetch PC
- branchFlag  in  1  taken branch resolved downstream; flush
- idex_memRead  in  1  instruction in ID/EX is a load
- idex_rt  in  5  load destination register
- if_id_instr  out  INSTR_W  registered instruction to decode
- if_id_pc  out  PC_W  registered PC to decode
- if_id_valid  out  1  registered; 0 = bubble
- opcjump  out  6  if_id_instr[31:26] to fetch jump control
- jumpPC  out  PC_W  if_id_instr[PC_W-1:0] to fetch
- hazardFlag  out  1  combinational; 1 = fetch may advance, 0 = hold PC
- idex_bubble  out  1  combinational; 1 = decode must load NOP controls into ID/EX this cycle

Behaviour:
- Reset (synchronous, active-high): if_id_instr=0, if_id_pc=0, if_id_valid=0, state=FILL. Outputs during reset: hazardFlag=1, idex_bubble=0.
- Decoded fields: rs=instr[25:21], rt=instr[20:16].
- uses_rt = opcode in {R-type 000000, SW 101011, BEQ 000100, BNE 000101}.
- load_use = (state==RUN) & if_id_valid & idex_memRead & (idex_rt!=0) & ((idex_rt==rs) | (uses_rt & idex_rt==rt)).
- hazardFlag = ~load_use; idex_bubble = load_use. Both are valid before the following negedge.
- Posedge update priority:
  - reset > branchFlag > load_use > normal capture.
  - branchFlag: instr=0 (NOP), valid=0, pc=PC; state→RUN. A simultaneous load_use is discarded because the flushed instruction is wrong-path.
  - load_use: hold instr/pc/valid; state→STALL.
  - normal: instr=Instruction, pc=PC, valid=1; state→RUN.
- FSM:
  - FILL: one cycle after reset. Load_use masked. Captures the PC=0 instruction; →RUN.
  - RUN: normal operation.
  - STALL: exactly one cycle. Load_use masked, which guarantees release. Captures normally at next posedge; →RUN, or →RUN with flush if branchFlag.
- Jumps: no flush needed. The fetch stage redirects at the negedge after the jump is captured, so the next capture is the target. A bubble (instr=0) decodes as opcode 0, never a jump.
- Back-to-back hazards: a new load_use is permitted in the cycle after STALL→RUN.
- Reset mid-stall returns to FILL with all outputs cleared.

Optional Feature:
- Macro: IFID_PERF_EN.
- With the macro: adds outputs stall_count[15:0] and flush_count[15:0]. Each saturating, cleared on reset, incremented on posedges where load_use / branchFlag take effect.
- Without the macro: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_RTYPE, OP_SW, OP_BEQ, OP_BNE, OP_LW, OP_J.
  - NOP instruction constant 32'h0.
  - FSM state enum {FILL, RUN, STALL}.
  - Register-field bit positions.
- One natural sub-module: load_use_detect (combinational compare producing load_use), reused later by the forwarding unit.

Test Plan:
- Reset, then Instruction=32'h8C010004 at PC=0 → after first posedge: valid=1, pc=0, instr=32'h8C010004, hazardFlag=1.
- IF/ID holds ADD r3,r1,r2 (32'h00221820); idex_memRead=1, idex_rt=1 → hazardFlag=0 and idex_bubble=1 in the same cycle. Next posedge: IF/ID unchanged, state=STALL, hazardFlag=1.
- Same as the previous case but idex_rt=0 → no stall, hazardFlag=1.
- SW with rt match (32'hAC010000, idex_rt=1, memRead=1) → stall. ADDI with rt match only (32'h20010005) → no stall.
- branchFlag=1 coincident with load_use → next posedge: instr=0, valid=0, state=RUN, no STALL entered.
- IF/ID holds J 0x3A (32'h0800003A) → opcjump=6'b000010, jumpPC=10'h03A. Next capture is the target instruction with valid=1.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, NOP, IF/ID FSM states and instruction field positions shared by the decode front end.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [31:0] NOP = 32'h0;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  typedef enum logic [1:0] {FILL, RUN, STALL} state_e;
  // Opcodes whose rt field is a source operand rather than a destination.
  function automatic logic uses_rt(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_SW || op == OP_BEQ || op == OP_BNE;
  endfunction
endpackage

// File: rtl/if_id_stage_if.sv
// if_id_stage_if: fetch/decode-facing signals of the IF/ID stage; IFID_PERF_EN adds the stall/flush counters.
interface if_id_stage_if #(parameter int PC_W = 10, parameter int INSTR_W = 32);
  logic [INSTR_W-1:0] Instruction;
  logic [PC_W-1:0] PC;
  logic branchFlag;
  logic idex_memRead;
  logic [4:0] idex_rt;
  logic [INSTR_W-1:0] if_id_instr;
  logic [PC_W-1:0] if_id_pc;
  logic if_id_valid;
  logic [5:0] opcjump;
  logic [PC_W-1:0] jumpPC;
  logic hazardFlag;
  logic idex_bubble;
`ifdef IFID_PERF_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;
`endif
  modport master (
    output Instruction, PC, branchFlag, idex_memRead, idex_rt,
`ifdef IFID_PERF_EN
    input stall_count, flush_count,
`endif
    input if_id_instr, if_id_pc, if_id_valid, opcjump, jumpPC, hazardFlag, idex_bubble
  );
  modport slave (
    input Instruction, PC, branchFlag, idex_memRead, idex_rt,
`ifdef IFID_PERF_EN
    output stall_count, flush_count,
`endif
    output if_id_instr, if_id_pc, if_id_valid, opcjump, jumpPC, hazardFlag, idex_bubble
  );
endinterface

// File: rtl/load_use_detect.sv
// load_use_detect: flags an instruction in decode that reads the destination of a load sitting in ID/EX.
module load_use_detect
  import mips_pkg::*;
(
  input  logic       en,
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       idex_memRead,
  input  logic [4:0] idex_rt,
  output logic       load_use
);
  // r0 is hardwired, so a load into it never creates a dependency.
  assign load_use = en && idex_memRead && idex_rt != 5'd0 &&
                    (idex_rt == rs || (uses_rt(op) && idex_rt == rt));
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with load-use stall and branch flush.
// Define IFID_PERF_EN to add saturating stall_count/flush_count outputs.
module if_id_stage
  import mips_pkg::*;
#(
  parameter int PC_W = 10,
  parameter int INSTR_W = 32
) (
  input logic clk,
  input logic reset,
  if_id_stage_if.slave bus
);
  state_e state, state_nx;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0] pc;
  logic valid;
  logic load_use;
  // Hazards are only raised from RUN: FILL has nothing valid yet and STALL must release.
  load_use_detect u_detect (
    .en          (state == RUN && valid && !reset),
    .op          (instr[OP_MSB:OP_LSB]),
    .rs          (instr[RS_MSB:RS_LSB]),
    .rt          (instr[RT_MSB:RT_LSB]),
    .idex_memRead(bus.idex_memRead),
    .idex_rt     (bus.idex_rt),
    .load_use    (load_use)
  );
  always_comb state_nx = (load_use && !bus.branchFlag) ? STALL : RUN;
  always_ff @(posedge clk)
    if (reset) state <= FILL;
    else state <= state_nx;
  // A branch flush wins over a stall: the stalled instruction is wrong-path.
  always_ff @(posedge clk)
    if (reset) begin
      instr <= '0;
      pc <= '0;
      valid <= 1'b0;
    end else if (bus.branchFlag) begin
      instr <= INSTR_W'(NOP);
      pc <= bus.PC;
      valid <= 1'b0;
    end else if (!load_use) begin
      instr <= bus.Instruction;
      pc <= bus.PC;
      valid <= 1'b1;
    end
  assign bus.if_id_instr = instr;
  assign bus.if_id_pc = pc;
  assign bus.if_id_valid = valid;
  assign bus.opcjump = instr[OP_MSB:OP_LSB];
  assign bus.jumpPC = instr[PC_W-1:0];
  assign bus.hazardFlag = !load_use;
  assign bus.idex_bubble = load_use;
`ifdef IFID_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
  always_ff @(posedge clk)
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.branchFlag && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
      if (load_use && !bus.branchFlag && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  assign bus.stall_count = stall_cnt;
  assign bus.flush_count = flush_cnt;
`endif
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed scoreboard bench for if_id_stage.
module tb_if_id_stage;
  typedef struct {
    logic [31:0] instr;
    logic [9:0] pc;
    logic valid;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  exp_t q[$];
  if_id_stage_if #(.PC_W(10), .INSTR_W(32)) bus ();
  if_id_stage #(.PC_W(10), .INSTR_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [9:0] p, input logic br, input logic mr, input logic [4:0] rt);
    bus.Instruction = i;
    bus.PC = p;
    bus.branchFlag = br;
    bus.idex_memRead = mr;
    bus.idex_rt = rt;
    #1;
  endtask

  task automatic push(input logic [31:0] i, input logic [9:0] p, input logic v);
    exp_t e;
    e.instr = i;
    e.pc = p;
    e.valid = v;
    q.push_back(e);
  endtask

  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    n_chk++;
    assert (q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, got 0 expected 1 entries", tag);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, ".instr"}, bus.if_id_instr, e.instr);
      chk({tag, ".pc"}, {22'd0, bus.if_id_pc}, {22'd0, e.pc});
      chk({tag, ".valid"}, {31'd0, bus.if_id_valid}, {31'd0, e.valid});
    end
  endtask

  task automatic haz(input string tag, input logic h);
    chk({tag, ".hazardFlag"}, {31'd0, bus.hazardFlag}, {31'd0, h});
    chk({tag, ".idex_bubble"}, {31'd0, bus.idex_bubble}, {31'd0, !h});
  endtask

  initial begin
    drive(32'h8C010004, 10'd0, 1'b0, 1'b0, 5'd0);
    push(32'h0, 10'd0, 1'b0);
    step("reset0");
    push(32'h0, 10'd0, 1'b0);
    step("reset1");
    haz("reset", 1'b1);
    reset = 1'b0;
    push(32'h8C010004, 10'd0, 1'b1);
    step("fill");
    haz("fill", 1'b1);
    // ADD r3,r1,r2 against a load into r1
    drive(32'h00221820, 10'd1, 1'b0, 1'b0, 5'd0);
    push(32'h00221820, 10'd1, 1'b1);
    step("add");
    drive(32'h00A43020, 10'd2, 1'b0, 1'b1, 5'd1);
    haz("add_rs_hit", 1'b0);
    push(32'h00221820, 10'd1, 1'b1);
    step("add_stall");
    haz("stall_release", 1'b1);
    push(32'h00A43020, 10'd2, 1'b1);
    step("after_stall");
    haz("add_nomatch", 1'b1);
    // idex_rt = 0 never stalls
    drive(32'h00221820, 10'd3, 1'b0, 1'b0, 5'd0);
    push(32'h00221820, 10'd3, 1'b1);
    step("add2");
    drive(32'hAC010000, 10'd4, 1'b0, 1'b1, 5'd0);
    haz("rt_zero", 1'b1);
    push(32'hAC010000, 10'd4, 1'b1);
    step("sw");
    drive(32'h20010005, 10'd5, 1'b0, 1'b1, 5'd1);
    haz("sw_rt_hit", 1'b0);
    push(32'hAC010000, 10'd4, 1'b1);
    step("sw_stall");
    haz("sw_release", 1'b1);
    push(32'h20010005, 10'd5, 1'b1);
    step("addi");
    haz("addi_rt_only", 1'b1);
    // branch coincident with load-use: flush, no stall
    drive(32'h00221820, 10'd6, 1'b0, 1'b1, 5'd1);
    push(32'h00221820, 10'd6, 1'b1);
    step("add3");
    haz("add3_hit", 1'b0);
    drive(32'h00A43020, 10'd7, 1'b1, 1'b1, 5'd1);
    push(32'h0, 10'd7, 1'b0);
    step("flush");
    drive(32'h00A43020, 10'd8, 1'b0, 1'b1, 5'd1);
    haz("after_flush", 1'b1);
    push(32'h00A43020, 10'd8, 1'b1);
    step("post_flush");
    // jump
    drive(32'h0800003A, 10'd9, 1'b0, 1'b0, 5'd0);
    push(32'h0800003A, 10'd9, 1'b1);
    step("jump");
    chk("opcjump", {26'd0, bus.opcjump}, 32'h2);
    chk("jumpPC", {22'd0, bus.jumpPC}, 32'h3A);
    drive(32'h20020007, 10'h3A, 1'b0, 1'b0, 5'd0);
    push(32'h20020007, 10'h3A, 1'b1);
    step("target");
    chk("opc_target", {26'd0, bus.opcjump}, 32'h8);
    // back-to-back hazards, then reset mid-stall
    drive(32'h00221820, 10'd11, 1'b0, 1'b1, 5'd2);
    push(32'h00221820, 10'd11, 1'b1);
    step("add4");
    haz("b2b_first", 1'b0);
    push(32'h00221820, 10'd11, 1'b1);
    step("b2b_stall1");
    haz("b2b_masked", 1'b1);
    drive(32'h00221820, 10'd12, 1'b0, 1'b1, 5'd1);
    push(32'h00221820, 10'd12, 1'b1);
    step("b2b_capture");
    haz("b2b_second", 1'b0);
    push(32'h00221820, 10'd12, 1'b1);
    step("b2b_stall2");
    reset = 1'b1;
    push(32'h0, 10'd0, 1'b0);
    step("mid_reset");
    haz("mid_reset", 1'b1);
    reset = 1'b0;
    drive(32'h00221820, 10'd0, 1'b0, 1'b1, 5'd1);
    haz("refill_masked", 1'b1);
    push(32'h00221820, 10'd0, 1'b1);
    step("refill");
    haz("refill_run", 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
